fifo112x_ctl: RTL and testbench



---
 rtl/fifo112x_ctl_if.sv | 43 ++++
 rtl/fifo112x_ctl.sv | 112 +++++++++++
 tb/tb_fifo112x_ctl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo112x_ctl_if.sv
// fifo112x_ctl_if: push/pop datapath and RAM-wrapper signals of fifo112x_ctl.
//   slave  : controller view (fifo112x_ctl)
//   master : environment view (datapath plus RAM wrapper)
// Signals:
//   push, push_data, pop, err_clr        requests from the datapath
//   rd_data, rd_vld                      read return
//   full, empty, afull, count, ovf, udf  status and error flags
//   ram_wa, ram_we, ram_di, ram_ra       RAM wrapper command side
//   ram_do                               RAM wrapper read data
interface fifo112x_ctl_if #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32
);
  logic               push;
  logic [WIDTH-1:0]   push_data;
  logic               pop;
  logic               err_clr;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_vld;
  logic               full;
  logic               empty;
  logic               afull;
  logic [ADDRBIT:0]   count;
  logic               ovf;
  logic               udf;
  logic [ADDRBIT-1:0] ram_wa;
  logic               ram_we;
  logic [WIDTH-1:0]   ram_di;
  logic [ADDRBIT-1:0] ram_ra;
  logic [WIDTH-1:0]   ram_do;

  modport master (
    output push, push_data, pop, err_clr, ram_do,
    input  rd_data, rd_vld, full, empty, afull, count, ovf, udf,
           ram_wa, ram_we, ram_di, ram_ra
  );

  modport slave (
    input  push, push_data, pop, err_clr, ram_do,
    output rd_data, rd_vld, full, empty, afull, count, ovf, udf,
           ram_wa, ram_we, ram_di, ram_ra
  );
endinterface

// File: rtl/fifo112x_ctl.sv
// fifo112x_ctl: single-clock FIFO controller in front of a registered
// dual-port RAM wrapper. Owns write/read pointers, total occupancy, readable
// count, flags, error reporting and the read-valid pipeline.
// Ports:
//   clk  single clock (RAM wrapper wclk/rclk tied to it)
//   rst  asynchronous, active-high reset
//   bus  fifo112x_ctl_if.slave: push/pop side, status, RAM command/data
// Optional feature: define FIFO112X_CTL_STICKY_ERR_EN for sticky ovf/udf
// cleared by err_clr; otherwise ovf/udf are one-cycle pulses.
module fifo112x_ctl #(
  parameter int ADDRBIT  = 5,
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 32,
  parameter int RDLAT    = 2,
  parameter int AFULL_TH = 28
) (
  input  logic             clk,
  input  logic             rst,
  fifo112x_ctl_if.slave    bus
);

  localparam logic [ADDRBIT-1:0] LAST_PTR = ADDRBIT'(DEPTH - 1);
  localparam logic [ADDRBIT:0]   DEPTH_C  = (ADDRBIT + 1)'(DEPTH);
  localparam logic [ADDRBIT:0]   AFULL_C  = (ADDRBIT + 1)'(AFULL_TH);

  logic [ADDRBIT-1:0] wptr;
  logic [ADDRBIT-1:0] rptr;
  logic [ADDRBIT:0]   count_q;
  logic [ADDRBIT:0]   rcnt;
  logic               push_dly;
  logic [RDLAT-1:0]   vld_pipe;
  logic               ovf_q;
  logic               udf_q;

  logic full_w;
  logic empty_w;
  logic push_acc;
  logic pop_acc;
  logic ovf_ev;
  logic udf_ev;

  // Acceptance is gated by rst so the RAM sees no write during reset.
  always_comb begin
    full_w   = (count_q == DEPTH_C);
    empty_w  = (rcnt == '0);
    pop_acc  = bus.pop & ~empty_w & ~rst;
    push_acc = bus.push & ~rst & (~full_w | pop_acc);
    ovf_ev   = bus.push & ~push_acc;
    udf_ev   = bus.pop & empty_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      rcnt     <= '0;
      push_dly <= 1'b0;
      vld_pipe <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push_acc) wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
      if (pop_acc)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;

      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Two-stage delay from push to readable: push_dly, then the rcnt
      // register itself. A word pushed in t is poppable from t+2, after the
      // wrapper has committed its write at the end of t+1.
      push_dly <= push_acc;
      rcnt     <= rcnt + (ADDRBIT + 1)'(push_dly) - (ADDRBIT + 1)'(pop_acc);

      vld_pipe[0] <= pop_acc;
      for (int unsigned i = 1; i < RDLAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end

`ifdef FIFO112X_CTL_STICKY_ERR_EN
      // A new event wins over a same-cycle clear.
      ovf_q <= ovf_ev | (ovf_q & ~bus.err_clr);
      udf_q <= udf_ev | (udf_q & ~bus.err_clr);
`else
      ovf_q <= ovf_ev;
      udf_q <= udf_ev;
`endif
    end
  end

`ifndef FIFO112X_CTL_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
`endif

  assign bus.ram_we  = push_acc;
  assign bus.ram_wa  = wptr;
  assign bus.ram_di  = bus.push_data;
  assign bus.ram_ra  = rptr;
  assign bus.rd_data = bus.ram_do;
  assign bus.rd_vld  = vld_pipe[RDLAT-1];
  assign bus.full    = full_w;
  assign bus.empty   = empty_w;
  assign bus.afull   = (count_q >= AFULL_C);
  assign bus.count   = count_q;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;

endmodule

// File: tb/tb_fifo112x_ctl.sv
module tb_fifo112x_ctl;
  localparam int ADDRBIT  = 5;
  localparam int DEPTH    = 32;
  localparam int WIDTH    = 32;
  localparam int RDLAT    = 2;
  localparam int AFULL_TH = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo112x_ctl_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) bus ();

  fifo112x_ctl #(
    .ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH),
    .RDLAT(RDLAT), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Registered dual-port RAM wrapper: write command registered, committed one
  // cycle later; read address registered, data registered (RDLAT = 2).
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               w_v = 1'b0;
  logic [ADDRBIT-1:0] w_a;
  logic [WIDTH-1:0]   w_d;
  logic [ADDRBIT-1:0] r_a;
  always @(posedge clk) begin
    if (w_v) mem[w_a] <= w_d;
    w_v <= bus.ram_we;
    w_a <= bus.ram_wa;
    w_d <= bus.ram_di;
    r_a <= bus.ram_ra;
    bus.ram_do <= mem[r_a];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO contents with push cycle stamps, pending reads.
  logic [WIDTH-1:0] mq[$];
  int               mt[$];
  logic [WIDTH-1:0] pd[$];
  int               pt[$];
  int               mcyc = 0;
  int               m_wa = 0;
  int               m_ra = 0;
  bit               m_ovf = 0;
  bit               m_udf = 0;

  always @(negedge clk) begin
    int  cnt, readable;
    bit  e_full, e_empty, pop_ok, push_ok, e_vld;
    mcyc++;
    if (rst) begin
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_afull", bus.afull, 0);
      chk("rst_rd_vld", bus.rd_vld, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_udf", bus.udf, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_wa", bus.ram_wa, 0);
      chk("rst_ram_ra", bus.ram_ra, 0);
      mq.delete(); mt.delete(); pd.delete(); pt.delete();
      m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0;
    end else begin
      cnt = mq.size();
      readable = 0;
      foreach (mt[i]) if (mt[i] + 2 <= mcyc) readable++;
      e_full  = (cnt == DEPTH);
      e_empty = (readable == 0);
      pop_ok  = bus.pop && !e_empty;
      push_ok = bus.push && (!e_full || pop_ok);
      e_vld   = (pt.size() > 0) && (pt[0] == mcyc);

      chk("m_count", bus.count, 64'(cnt));
      chk("m_full", bus.full, 64'(e_full));
      chk("m_empty", bus.empty, 64'(e_empty));
      chk("m_afull", bus.afull, 64'(cnt >= AFULL_TH));
      chk("m_rd_vld", bus.rd_vld, 64'(e_vld));
      if (e_vld) begin
        chk("m_rd_data", bus.rd_data, 64'(pd[0]));
        void'(pd.pop_front()); void'(pt.pop_front());
      end
      chk("m_ram_we", bus.ram_we, 64'(push_ok));
      chk("m_ram_wa", bus.ram_wa, 64'(m_wa));
      chk("m_ram_ra", bus.ram_ra, 64'(m_ra));
      if (push_ok) chk("m_ram_di", bus.ram_di, 64'(bus.push_data));
      chk("m_ovf", bus.ovf, 64'(m_ovf));
      chk("m_udf", bus.udf, 64'(m_udf));

      if (pop_ok) begin
        pd.push_back(mq[0]); pt.push_back(mcyc + RDLAT);
        void'(mq.pop_front()); void'(mt.pop_front());
        m_ra = (m_ra + 1) % DEPTH;
      end
      if (push_ok) begin
        mq.push_back(bus.push_data); mt.push_back(mcyc);
        m_wa = (m_wa + 1) % DEPTH;
      end
`ifdef FIFO112X_CTL_STICKY_ERR_EN
      m_ovf = (m_ovf && !bus.err_clr) || (bus.push && !push_ok);
      m_udf = (m_udf && !bus.err_clr) || (bus.pop && e_empty);
`else
      m_ovf = bus.push && !push_ok;
      m_udf = bus.pop && e_empty;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic [WIDTH-1:0] d, input bit q);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    drive(0, '0, 0);
    bus.err_clr = 1'b0;
    repeat (3) step();
    chk("lit_rst_empty", bus.empty, 1);
    chk("lit_rst_count", bus.count, 0);
    rst = 1'b0;
    step();

    // Single word: push in cycle 0, visible to pop in cycle 2, data in cycle 4.
    drive(1, 32'hA5A5_0001, 0);
    step();
    drive(0, '0, 0);
    chk("lit_c1_count", bus.count, 1);
    chk("lit_c1_empty", bus.empty, 1);
    step();
    chk("lit_c2_empty", bus.empty, 0);
    drive(0, '0, 1);
    #1 chk("lit_c2_ram_ra", bus.ram_ra, 0);
    step();
    drive(0, '0, 0);
    chk("lit_c3_count", bus.count, 0);
    step();
    chk("lit_c4_rd_vld", bus.rd_vld, 1);
    chk("lit_c4_rd_data", bus.rd_data, 32'hA5A5_0001);

    // Fill with 0..31 starting at address 1 so both pointers wrap.
    for (int i = 0; i < 32; i++) begin
      drive(1, 32'(i), 0);
      step();
      chk("lit_fill_count", bus.count, 64'(i + 1));
      chk("lit_fill_afull", bus.afull, 64'((i + 1) >= 28));
    end
    chk("lit_full", bus.full, 1);
    drive(1, 32'h99, 0);
    #1 chk("lit_ovf_no_we", bus.ram_we, 0);
    step();
    drive(0, '0, 0);
    chk("lit_ovf_set", bus.ovf, 1);
    chk("lit_ovf_count", bus.count, 32);
    step();
`ifdef FIFO112X_CTL_STICKY_ERR_EN
    chk("lit_ovf_hold", bus.ovf, 1);
`else
    chk("lit_ovf_pulse", bus.ovf, 0);
`endif
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("lit_ovf_clr", bus.ovf, 0);

    // Full with simultaneous push and pop: both accepted.
    drive(1, 32'd100, 1);
    #1 chk("lit_both_we", bus.ram_we, 1);
    step();
    drive(0, '0, 1);
    chk("lit_both_count", bus.count, 32);
    chk("lit_both_ovf", bus.ovf, 0);
    chk("lit_both_full", bus.full, 1);
    for (int j = 0; j < 32; j++) begin
      step();
      if (j == 0) begin
        chk("lit_drain0_vld", bus.rd_vld, 1);
        chk("lit_drain0_data", bus.rd_data, 0);
      end
      if (j == 1) chk("lit_drain1_data", bus.rd_data, 1);
      if (j == 31) drive(0, '0, 0);
    end
    step();
    chk("lit_drain_last", bus.rd_data, 100);
    chk("lit_drain_count", bus.count, 0);
    chk("lit_drain_empty", bus.empty, 1);

    // Pop while empty.
    drive(0, '0, 1);
    step();
    drive(0, '0, 0);
    chk("lit_udf_set", bus.udf, 1);
    chk("lit_udf_vld0", bus.rd_vld, 0);
    step();
    chk("lit_udf_vld1", bus.rd_vld, 0);
`ifdef FIFO112X_CTL_STICKY_ERR_EN
    chk("lit_udf_hold", bus.udf, 1);
`else
    chk("lit_udf_pulse", bus.udf, 0);
`endif
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("lit_udf_clr", bus.udf, 0);

    // Reset mid-stream with reads in flight.
    for (int i = 0; i < 13; i++) begin
      drive(1, 32'(200 + i), 0);
      step();
    end
    drive(0, '0, 0);
    step();
    step();
    drive(0, '0, 1);
    repeat (3) step();
    drive(0, '0, 0);
    chk("lit_mid_count", bus.count, 10);
    #2 rst = 1'b1;
    #1;
    chk("lit_mid_rst_vld", bus.rd_vld, 0);
    chk("lit_mid_rst_count", bus.count, 0);
    chk("lit_mid_rst_empty", bus.empty, 1);
    step();
    step();
    rst = 1'b0;
    step();
    drive(1, 32'h1234, 0);
    #1 chk("lit_post_wa", bus.ram_wa, 0);
    step();
    drive(0, '0, 0);
    step();
    drive(0, '0, 1);
    #1 chk("lit_post_ra", bus.ram_ra, 0);
    step();
    drive(0, '0, 0);
    step();
    chk("lit_post_vld", bus.rd_vld, 1);
    chk("lit_post_data", bus.rd_data, 32'h1234);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
